// File: rtl/vector_pkg.sv
// Shared fixed-point vector types for the ray pipeline, plus the dispatcher FSM
// encoding and its special Q8.24 constants.
package vector_pkg;

  typedef logic signed [31:0] fp;  // Q8.24

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } disp_state_t;

  localparam fp FP_NEG_ONE = 32'shFF000000;
  localparam fp FP_MAX     = 32'sh7FFFFFFF;

  function automatic vec3 make_vec3(input fp x, input fp y, input fp z);
    vec3 v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

endpackage

// File: rtl/ray_dispatcher.sv
// Walks a WIDTH x HEIGHT raster, issues one primary ray per pixel to the marcher,
// waits for its result (or a timeout) and presents it downstream with a handshake.
module ray_dispatcher
  import vector_pkg::*;
#(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter fp  X_STEP  = fp'(32'sd33554432 / WIDTH),
  parameter fp  Y_STEP  = X_STEP,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  vec3         cam_origin,
  output vec3         ray_origin,
  output vec3         ray_dir,
  output logic        ray_valid,
  input  logic        march_valid,
  input  logic        march_hit,
  input  fp           march_dist,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_hit,
  output fp           pix_dist,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam fp           X_START   = fp'(-(WIDTH / 2) * X_STEP);
  localparam fp           Y_START   = fp'((HEIGHT / 2) * Y_STEP);
  localparam logic [11:0] X_LAST    = 12'(WIDTH - 1);
  localparam logic [11:0] Y_LAST    = 12'(HEIGHT - 1);
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

  disp_state_t state_reg;
  logic [11:0] x_reg, y_reg;
  vec3         origin_reg;
  fp           dir_x_reg, dir_y_reg, dir_z_reg;
  logic        hit_reg;
  fp           dist_reg;
  logic        timeout_reg;
  logic        done_reg;
  logic [31:0] wait_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      origin_reg   <= '0;
      dir_x_reg    <= '0;
      dir_y_reg    <= '0;
      dir_z_reg    <= '0;
      hit_reg      <= 1'b0;
      dist_reg     <= '0;
      timeout_reg  <= 1'b0;
      done_reg     <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // The done cycle is already IDLE; a start there must not launch a frame.
          if (start && !done_reg) begin
            origin_reg  <= cam_origin;
            x_reg       <= '0;
            y_reg       <= '0;
            timeout_reg <= 1'b0;
            dir_x_reg   <= X_START;
            dir_y_reg   <= Y_START;
            dir_z_reg   <= FP_NEG_ONE;
            state_reg   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt_reg <= '0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (march_valid) begin
            hit_reg   <= march_hit;
            dist_reg  <= march_dist;
            state_reg <= ST_OUTPUT;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            hit_reg     <= 1'b0;
            dist_reg    <= FP_MAX;
            timeout_reg <= 1'b1;
            state_reg   <= ST_OUTPUT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end
        end
        ST_OUTPUT: begin
          if (pix_ready) begin
            // Direction advances incrementally alongside the raster position.
            if (x_reg == X_LAST) begin
              x_reg     <= '0;
              y_reg     <= y_reg + 12'd1;
              dir_x_reg <= X_START;
              dir_y_reg <= dir_y_reg - Y_STEP;
            end else begin
              x_reg     <= x_reg + 12'd1;
              dir_x_reg <= dir_x_reg + X_STEP;
            end
            if (x_reg == X_LAST && y_reg == Y_LAST) begin
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_ISSUE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ray_valid   = (state_reg == ST_ISSUE);
  assign pix_valid   = (state_reg == ST_OUTPUT);
  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign timeout_err = timeout_reg;
  assign ray_origin  = origin_reg;
  assign ray_dir     = make_vec3(dir_x_reg, dir_y_reg, dir_z_reg);
  assign pix_hit     = hit_reg;
  assign pix_dist    = dist_reg;
  assign pix_x       = x_reg;
  assign pix_y       = y_reg;
  assign pix_sof     = pix_valid && (x_reg == 12'd0) && (y_reg == 12'd0);
  assign pix_eol     = pix_valid && (x_reg == X_LAST);

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher on a 4x2 raster with a hand-driven marcher:
// normal frame, stalled output, silent marcher (timeout) and reset during WAIT.
module tb_ray_dispatcher;
  import vector_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  vec3         cam_origin;
  vec3         ray_origin;
  vec3         ray_dir;
  logic        ray_valid;
  logic        march_valid;
  logic        march_hit;
  fp           march_dist;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_hit;
  fp           pix_dist;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        pix_sof;
  logic        pix_eol;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;
  int hs_total = 0;
  int done_total = 0;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [31:0] dx;
    logic [31:0] dy;
    logic        sof;
    logic        eol;
  } pix_vec_t;

  pix_vec_t tbl[8];

  always #5 clk = ~clk;

  ray_dispatcher #(
    .WIDTH  (4),
    .HEIGHT (2),
    .X_STEP (32'sh00800000),
    .Y_STEP (32'sh00800000),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cam_origin (cam_origin),
    .ray_origin (ray_origin),
    .ray_dir    (ray_dir),
    .ray_valid  (ray_valid),
    .march_valid(march_valid),
    .march_hit  (march_hit),
    .march_dist (march_dist),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_hit    (pix_hit),
    .pix_dist   (pix_dist),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  always @(posedge clk) begin
    if (pix_valid && pix_ready) hs_total++;
    if (done) done_total++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_ray(output int ok);
    ok = 0;
    for (int n = 0; n < 40 && ok == 0; n++) begin
      @(negedge clk);
      if (ray_valid) ok = 1;
    end
  endtask

  task automatic wait_pix(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 40 && cycles < 0; n++) begin
      @(negedge clk);
      if (pix_valid) cycles = n;
    end
  endtask

  // mode 0: normal + ignored starts, 1: stall at (1,0), 2: silent marcher
  task automatic run_frame(input int mode, input vec3 org);
    int hs0;
    int dn0;
    int ok;
    int cyc;
    int bad;
    logic [31:0] exp_dist;
    logic        exp_hit;
    hs0 = hs_total;
    dn0 = done_total;
    cam_origin = org;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cam_origin = make_vec3(32'sh11111111, 32'sh22222222, 32'sh33333333);
    chk("start_latency_ray_valid", 32'(ray_valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        wait_ray(ok);
        chk("ray_valid_seen", 32'(ok), 32'd1);
      end
      chk("ray_dir_x", ray_dir.x, tbl[i].dx);
      chk("ray_dir_y", ray_dir.y, tbl[i].dy);
      chk("ray_dir_z", ray_dir.z, 32'hFF000000);
      chk("ray_origin", 32'(ray_origin == org), 32'd1);
      chk("busy_in_frame", 32'(busy), 32'd1);
      @(negedge clk);
      chk("ray_valid_one_cycle", 32'(ray_valid), 32'd0);
      if (mode == 0 && i == 2) start = 1'b1;
      if (mode != 2) begin
        exp_hit  = i[0];
        exp_dist = 32'h00010000 * 32'(i + 1) + ((mode == 1) ? 32'h01000000 : 32'd0);
        @(negedge clk);
        start = 1'b0;
        march_valid = 1'b1;
        march_hit = exp_hit;
        march_dist = exp_dist;
        @(negedge clk);
        march_valid = 1'b0;
        march_dist = 32'h0BADBEEF;
        chk("pix_valid_latency", 32'(pix_valid), 32'd1);
      end else begin
        exp_hit  = 1'b0;
        exp_dist = 32'h7FFFFFFF;
        wait_pix(cyc);
        // cyc counts from the first WAIT cycle: 16 silent WAIT cycles, then OUTPUT
        if (i == 0) chk("timeout_latency", 32'(cyc), 32'd16);
        else chk("timeout_pix_seen", 32'(cyc > 0), 32'd1);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
      end
      chk("pix_x", 32'(pix_x), 32'(tbl[i].x));
      chk("pix_y", 32'(pix_y), 32'(tbl[i].y));
      chk("pix_sof", 32'(pix_sof), 32'(tbl[i].sof));
      chk("pix_eol", 32'(pix_eol), 32'(tbl[i].eol));
      chk("pix_hit", 32'(pix_hit), 32'(exp_hit));
      chk("pix_dist", pix_dist, exp_dist);
      chk("ray_dir_x_stable", ray_dir.x, tbl[i].dx);
      $display("pixel mode=%0d x=%0d y=%0d hit=%0d dist=%h sof=%0d eol=%0d",
               mode, pix_x, pix_y, pix_hit, pix_dist, pix_sof, pix_eol);
      if (mode == 1 && i == 1) begin
        pix_ready = 1'b0;
        bad = 0;
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          if (!pix_valid || ray_valid || pix_x != 12'd1 || pix_y != 12'd0 ||
              pix_dist != exp_dist || pix_hit != exp_hit) bad++;
        end
        chk("stall_hold_bad_cycles", 32'(bad), 32'd0);
        pix_ready = 1'b1;
      end
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_after_frame", 32'(busy), 32'd0);
    if (mode == 0) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("start_on_done_ignored", 32'(busy || ray_valid), 32'd0);
    chk("pixel_count", 32'(hs_total - hs0), 32'd8);
    chk("done_count", 32'(done_total - dn0), 32'd1);
  endtask

  initial begin
    int ok;
    int bad;
    tbl[0] = '{12'd0, 12'd0, 32'hFF000000, 32'h00800000, 1'b1, 1'b0};
    tbl[1] = '{12'd1, 12'd0, 32'hFF800000, 32'h00800000, 1'b0, 1'b0};
    tbl[2] = '{12'd2, 12'd0, 32'h00000000, 32'h00800000, 1'b0, 1'b0};
    tbl[3] = '{12'd3, 12'd0, 32'h00800000, 32'h00800000, 1'b0, 1'b1};
    tbl[4] = '{12'd0, 12'd1, 32'hFF000000, 32'h00000000, 1'b0, 1'b0};
    tbl[5] = '{12'd1, 12'd1, 32'hFF800000, 32'h00000000, 1'b0, 1'b0};
    tbl[6] = '{12'd2, 12'd1, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    tbl[7] = '{12'd3, 12'd1, 32'h00800000, 32'h00000000, 1'b0, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    cam_origin = make_vec3(32'sh0, 32'sh0, 32'sh01000000);
    march_valid = 1'b0;
    march_hit = 1'b0;
    march_dist = '0;
    pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_flags", {24'd0, ray_valid, pix_valid, busy, done, timeout_err,
                      pix_hit, pix_sof, pix_eol}, 32'd0);
    chk("rst_pix_xy", {8'd0, pix_x, pix_y}, 32'd0);
    chk("rst_pix_dist", pix_dist, 32'd0);
    chk("rst_ray_origin", 32'(ray_origin != '0), 32'd0);
    chk("rst_ray_dir", 32'(ray_dir != '0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, make_vec3(32'sh0, 32'sh0, 32'sh01000000));
    run_frame(1, make_vec3(32'sh00400000, 32'shFFC00000, 32'sh02000000));
    run_frame(2, make_vec3(32'sh0, 32'sh0, 32'sh01000000));
    chk("timeout_err_sticky_idle", 32'(timeout_err), 32'd1);

    // New start clears the sticky flag; then reset lands during WAIT.
    cam_origin = make_vec3(32'sh0, 32'sh0, 32'sh01000000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("timeout_err_cleared_on_start", 32'(timeout_err), 32'd0);
    chk("ray_valid_after_start", 32'(ray_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wait_rst_flags", {24'd0, ray_valid, pix_valid, busy, done, timeout_err,
                           pix_hit, pix_sof, pix_eol}, 32'd0);
    chk("wait_rst_ray_dir", 32'(ray_dir != '0), 32'd0);
    chk("wait_rst_ray_origin", 32'(ray_origin != '0), 32'd0);
    march_valid = 1'b1;
    march_hit = 1'b1;
    march_dist = 32'h00123456;
    @(negedge clk);
    march_valid = 1'b0;
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      if (pix_valid || busy || ray_valid || pix_hit || pix_dist != 32'd0) bad++;
      @(negedge clk);
    end
    chk("late_march_ignored", 32'(bad), 32'd0);
    $display("reset_in_wait late_march bad_cycles=%0d", bad);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
